uart_rx_word_fifo: RTL and testbench
====================================

Name: uart_rx_word_fifo

Overview:
Parametrised successor to the current UART receive FIFO. It accepts byte strobes from the UART receiver, packs BYTES_PER_WORD bytes little-endian into one word, and buffers the words in a circular FIFO of DEPTH entries. The CPU side reads through a show-ahead port and sees level, empty, full and overrun status. The block sits between the UART receiver and the datapath write-back mux, in the single CPU clock domain; any synchronisation happens upstream.

Parameters:
BYTE_W, 8, width of one received symbol
BYTES_PER_WORD, 4, bytes packed per FIFO word (1..8)
DEPTH, 16, FIFO depth in words (power of two, >=2)
TIMEOUT_CYCLES, 1024, idle cycles before a partial word is force-pushed (optional feature only)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous reset, active-low
rx_valid  in  1  one-cycle strobe: rx_byte is valid
rx_byte  in  BYTE_W  received byte
rd_en  in  1  pop head word (one pop per cycle it is high)
flush  in  1  synchronous clear of FIFO and packer
clr_overrun  in  1  clears the sticky overrun flag
rd_data  out  BYTE_W*BYTES_PER_WORD  head word (show-ahead)
fifo_empty  out  1  no words stored
fifo_full  out  1  DEPTH words stored
level  out  $clog2(DEPTH)+1  words stored
partial_cnt  out  $clog2(BYTES_PER_WORD)+1  bytes held in the packer
overrun  out  1  sticky: a completed word was dropped

Behaviour:
- Reset (reset=0, async): wr_ptr=rd_ptr=0, level=0, fifo_empty=1, fifo_full=0, partial_cnt=0, overrun=0, rd_data=0, packer shadow=0.
- Packer:
  - Byte k of a word goes to lanes [k*BYTE_W +: BYTE_W], so byte 0 lands in the LSBs.
  - An rx_valid with partial_cnt<BYTES_PER_WORD-1 stores the byte and increments partial_cnt.
  - The rx_valid carrying the last byte forms {rx_byte, shadow} and requests a push in the same cycle. partial_cnt returns to 0.
- Push:
  - Accepted if !fifo_full, or if fifo_full and rd_en are both high in the same cycle (the pop frees the slot).
  - Otherwise the word is dropped, overrun is set to 1, partial_cnt returns to 0, and no pointer moves.
- Pop:
  - With rd_en=1 and !fifo_empty, rd_ptr advances. rd_data shows the new head on the next cycle.
  - rd_en while empty is ignored (no pointer change, no flag).
  - A push and a rd_en in the same cycle when empty: the push happens and the pop is ignored.
- rd_data:
  - Equals mem[rd_ptr] whenever !fifo_empty; holds the last value when empty.
  - Write-to-read latency: a word pushed at edge N is visible on rd_data and fifo_empty=0 after edge N (1 cycle).
- Pointers: $clog2(DEPTH) bits, wrap modulo DEPTH. level updates by +1 on push only, -1 on pop only, and is unchanged when both occur. fifo_full=(level==DEPTH), fifo_empty=(level==0).
- flush=1:
  - Next edge clears pointers, level and partial_cnt.
  - Takes priority over rx_valid and rd_en in the same cycle; that byte is discarded.
  - overrun is unaffected.
- overrun: clr_overrun clears it. If clr_overrun and a new drop occur in the same cycle, the set wins.
- Reset mid-word or mid-operation returns everything to reset values; any partial word is lost.

Optional Feature:
RX_TIMEOUT_FLUSH_EN.
- Defined:
  - An idle counter resets on every rx_valid and counts while partial_cnt>0.
  - When the counter reaches TIMEOUT_CYCLES, the partial word is pushed with the unfilled upper lanes set to 0, and partial_cnt returns to 0.
  - The push obeys the same full/overrun rules as a normal push.
  - A timeout coinciding with rx_valid is not taken (the byte resets the counter).
  - The counter is cleared by reset and by flush.
- Undefined: no counter; a partial word waits indefinitely.

Decomposition:
- Package uart_rx_pkg: BYTE_W default, derived widths (PTR_W=$clog2(DEPTH), CNT_W), and the word type.
- One sub-module, rx_byte_packer: shadow register, partial_cnt, optional timeout, push_req/push_word outputs.
- The FIFO storage and pointers stay in the top module.

Test Plan:
- Single word: bytes 0x11,0x22,0x33,0x44 -> one cycle after the 4th strobe, rd_data=0x44332211, level=1, fifo_empty=0.
- Fill and overrun (DEPTH=16): 17 words without rd_en -> fifo_full=1, level=16, overrun=1; the 17th word is absent and the head is still word 0.
- Push+pop while full: complete a word in the same cycle as rd_en -> level stays 16, overrun stays 0, the new word is read last.
- Wrap-around: stream 40 words while popping every other cycle -> read order matches write order across pointer wrap; level never exceeds 16.
- Flush and reset: 2 bytes buffered, assert flush together with rx_valid -> partial_cnt=0, level=0, byte discarded. Separately, pull reset low mid-word -> all outputs return to reset values immediately.
- RX_TIMEOUT_FLUSH_EN, TIMEOUT_CYCLES=8: send 0xAA,0xBB then idle -> after 8 idle cycles, rd_data=0x0000BBAA and level=1.

Source files
------------

// File: rtl/uart_rx_word_fifo_pkg.sv
// uart_rx_pkg: shared defaults, derived widths and the default word type for
// the UART receive word FIFO.
//
// Derived widths are exposed both as default-build localparams and as
// constant functions. Parameterised modules use the functions to size
// their own signals.
package uart_rx_pkg;

  localparam int unsigned DEF_BYTE_W         = 8;
  localparam int unsigned DEF_BYTES_PER_WORD = 4;
  localparam int unsigned DEF_DEPTH          = 16;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 1024;

  // Pointer width for a power-of-two FIFO depth.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth);
  endfunction

  // Width of a counter that must hold the value n itself.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n) + 1;
  endfunction

  localparam int unsigned DEF_PTR_W  = ptr_width(DEF_DEPTH);
  localparam int unsigned DEF_CNT_W  = cnt_width(DEF_BYTES_PER_WORD);
  localparam int unsigned DEF_WORD_W = DEF_BYTE_W * DEF_BYTES_PER_WORD;

  typedef logic [DEF_WORD_W-1:0] word_t;

endpackage

// File: rtl/uart_rx_word_fifo_packer.sv
// rx_byte_packer: collects BYTES_PER_WORD received bytes little-endian into
// one word and requests a FIFO push when the word is complete.
//
// Optional feature macro: RX_TIMEOUT_FLUSH_EN. When defined, a partial word
// that sees no new byte for TIMEOUT_CYCLES cycles is pushed with its unfilled
// upper lanes zero.
//
// Ports:
//   clk, reset        clock (rising edge), asynchronous active-low reset
//   rx_valid, rx_byte byte strobe and data from the UART receiver
//   flush             synchronous clear; discards any partial word
//   partial_cnt       bytes currently held
//   push_req          combinational: a word is ready this cycle
//   push_word         combinational: the word to push
module rx_byte_packer
  import uart_rx_pkg::*;
#(
  parameter int unsigned BYTE_W         = DEF_BYTE_W,
  parameter int unsigned BYTES_PER_WORD = DEF_BYTES_PER_WORD,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               rx_valid,
  input  logic [BYTE_W-1:0]                  rx_byte,
  input  logic                               flush,
  output logic [$clog2(BYTES_PER_WORD):0]    partial_cnt,
  output logic                               push_req,
  output logic [BYTE_W*BYTES_PER_WORD-1:0]   push_word
);

  localparam int unsigned CNT_W  = cnt_width(BYTES_PER_WORD);
  localparam int unsigned WORD_W = BYTE_W * BYTES_PER_WORD;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BYTES_PER_WORD - 1);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("rx_byte_packer: TIMEOUT_CYCLES must be at least 1");
  end

  // Lanes above partial_cnt are always zero: the shadow is cleared whenever a
  // word leaves, which is what gives a timed-out word its zero upper lanes.
  logic [WORD_W-1:0] shadow;
  logic              last_byte;
  logic              timeout_hit;

  always_comb begin
    last_byte = rx_valid && !flush && (partial_cnt == LAST_IDX);
    push_req  = last_byte || timeout_hit;
    push_word = shadow;
    if (rx_valid) begin
      push_word[partial_cnt*BYTE_W +: BYTE_W] = rx_byte;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      partial_cnt <= '0;
      shadow      <= '0;
    end else if (flush || push_req) begin
      partial_cnt <= '0;
      shadow      <= '0;
    end else if (rx_valid) begin
      shadow[partial_cnt*BYTE_W +: BYTE_W] <= rx_byte;
      partial_cnt                          <= partial_cnt + CNT_W'(1);
    end
  end

`ifdef RX_TIMEOUT_FLUSH_EN
  localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [IDLE_W-1:0] idle_cnt;

  // Fires on the TIMEOUT_CYCLES-th idle cycle so the push lands on that edge.
  // A byte arriving in the same cycle wins and restarts the count.
  assign timeout_hit = (partial_cnt != '0) && !rx_valid && !flush &&
                       (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idle_cnt <= '0;
    end else if (flush || rx_valid || timeout_hit || partial_cnt == '0) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + IDLE_W'(1);
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

endmodule

// File: rtl/uart_rx_word_fifo.sv
// uart_rx_word_fifo: packs UART receive bytes into words and buffers them in
// a circular FIFO read by the CPU through a show-ahead port.
//
// Optional feature macro: RX_TIMEOUT_FLUSH_EN (idle timeout pushes a partial
// word; see rx_byte_packer).
//
// Ports:
//   clk, reset    clock (rising edge), asynchronous active-low reset
//   rx_valid      one-cycle strobe qualifying rx_byte
//   rx_byte       received byte
//   rd_en         pop the head word (ignored when empty)
//   flush         synchronous clear of FIFO and packer; overrun is kept
//   clr_overrun   clears the sticky overrun flag (a same-cycle drop wins)
//   rd_data       head word, registered; holds its last value when empty
//   fifo_empty    no words stored
//   fifo_full     DEPTH words stored
//   level         words stored
//   partial_cnt   bytes held in the packer
//   overrun       sticky: a completed word was dropped because the FIFO was full
module uart_rx_word_fifo
  import uart_rx_pkg::*;
#(
  parameter int unsigned BYTE_W         = DEF_BYTE_W,
  parameter int unsigned BYTES_PER_WORD = DEF_BYTES_PER_WORD,
  parameter int unsigned DEPTH          = DEF_DEPTH,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               rx_valid,
  input  logic [BYTE_W-1:0]                  rx_byte,
  input  logic                               rd_en,
  input  logic                               flush,
  input  logic                               clr_overrun,
  output logic [BYTE_W*BYTES_PER_WORD-1:0]   rd_data,
  output logic                               fifo_empty,
  output logic                               fifo_full,
  output logic [$clog2(DEPTH):0]             level,
  output logic [$clog2(BYTES_PER_WORD):0]    partial_cnt,
  output logic                               overrun
);

  localparam int unsigned PTR_W  = ptr_width(DEPTH);
  localparam int unsigned LVL_W  = PTR_W + 1;
  localparam int unsigned WORD_W = BYTE_W * BYTES_PER_WORD;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_rx_word_fifo: DEPTH must be a power of two >= 2");
  end
  if (BYTES_PER_WORD < 1 || BYTES_PER_WORD > 8) begin : g_bad_bpw
    $error("uart_rx_word_fifo: BYTES_PER_WORD must be 1..8");
  end

  logic [WORD_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  rd_ptr_nxt;
  logic [LVL_W-1:0]  level_nxt;

  logic              push_req;
  logic [WORD_W-1:0] push_word;
  logic              push_ok;
  logic              pop_ok;
  logic              drop;

  rx_byte_packer #(
    .BYTE_W         (BYTE_W),
    .BYTES_PER_WORD (BYTES_PER_WORD),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_packer (
    .clk         (clk),
    .reset       (reset),
    .rx_valid    (rx_valid),
    .rx_byte     (rx_byte),
    .flush       (flush),
    .partial_cnt (partial_cnt),
    .push_req    (push_req),
    .push_word   (push_word)
  );

  assign fifo_empty = (level == '0);
  assign fifo_full  = (level == LVL_W'(DEPTH));

  // The packer never requests a push during flush, so push_ok and drop are
  // already gated by it; only the pop needs an explicit flush term.
  always_comb begin
    pop_ok     = rd_en && !fifo_empty && !flush;
    push_ok    = push_req && (!fifo_full || rd_en);
    drop       = push_req && fifo_full && !rd_en;
    rd_ptr_nxt = pop_ok ? rd_ptr + PTR_W'(1) : rd_ptr;
    level_nxt  = level;
    if (push_ok && !pop_ok) begin
      level_nxt = level + LVL_W'(1);
    end else if (pop_ok && !push_ok) begin
      level_nxt = level - LVL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_word;
    end
  end

  // rd_data is registered from the post-edge head. When the word being
  // written this cycle becomes the head (FIFO empty, or drained by this pop)
  // it is forwarded directly, giving one-cycle write-to-read latency.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      rd_data <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      rd_ptr <= rd_ptr_nxt;
      level  <= level_nxt;
      if (level_nxt != '0) begin
        rd_data <= (push_ok && wr_ptr == rd_ptr_nxt) ? push_word : mem[rd_ptr_nxt];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end else if (clr_overrun) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_word_fifo.sv
// Testbench for uart_rx_word_fifo (default parameters, TIMEOUT_CYCLES=8).
// Stimulus queues the words it expects to be stored; a monitor compares the
// head word against that queue on every cycle that pops a non-empty FIFO.
module tb_uart_rx_word_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic        rd_en;
  logic        flush;
  logic        clr_overrun;
  logic [31:0] rd_data;
  logic        fifo_empty;
  logic        fifo_full;
  logic [4:0]  level;
  logic [2:0]  partial_cnt;
  logic        overrun;

  int unsigned n_pass   = 0;
  int unsigned n_checks = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  uart_rx_word_fifo #(
    .BYTE_W         (8),
    .BYTES_PER_WORD (4),
    .DEPTH          (16),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_valid    (rx_valid),
    .rx_byte     (rx_byte),
    .rd_en       (rd_en),
    .flush       (flush),
    .clr_overrun (clr_overrun),
    .rd_data     (rd_data),
    .fifo_empty  (fifo_empty),
    .fifo_full   (fifo_full),
    .level       (level),
    .partial_cnt (partial_cnt),
    .overrun     (overrun)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  // Monitor: any cycle that pops a non-empty FIFO must present the oldest
  // expected word.
  logic [31:0] mon_exp;
  always @(negedge clk) begin
    if (reset === 1'b1 && rd_en && !fifo_empty) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL pop_order: got 0x%0h, expected no stored word", rd_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (rd_data === mon_exp) n_pass++;
        else $display("FAIL pop_order: got 0x%0h, expected 0x%0h", rd_data, mon_exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic rd);
    rx_valid = 1'b1;
    rx_byte  = b;
    rd_en    = rd;
    tick();
    rx_valid = 1'b0;
    rd_en    = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input logic rd_last, input logic stored);
    if (stored) exp_q.push_back(w);
    for (int k = 0; k < 4; k++) send_byte(w[k*8 +: 8], (k == 3) && rd_last);
  endtask

  task automatic drain(input int n);
    rd_en = 1'b1;
    repeat (n) tick();
    rd_en = 1'b0;
  endtask

  function automatic logic [31:0] word_of(input int i);
    logic [7:0] b;
    b = i[7:0];
    return {8'hC0 + b, 8'h5A, 8'hA5, b};
  endfunction

  int   lvl;
  int   max_dut;
  logic ph;
  logic p;
  logic r;
  logic acc;
  logic pp;

  initial begin
    reset = 1'b0; rx_valid = 1'b0; rx_byte = '0; rd_en = 1'b0;
    flush = 1'b0; clr_overrun = 1'b0;
    repeat (2) tick();
    check("reset_level", 32'(level), 0);
    check("reset_empty", 32'(fifo_empty), 1);
    check("reset_full", 32'(fifo_full), 0);
    check("reset_partial", 32'(partial_cnt), 0);
    check("reset_overrun", 32'(overrun), 0);
    check("reset_rd_data", rd_data, 0);
    reset = 1'b1;
    tick();

    // Single word, little-endian packing, one-cycle latency.
    exp_q.push_back(32'h44332211);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    check("partial_after_2", 32'(partial_cnt), 2);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b0);
    check("single_rd_data", rd_data, 32'h44332211);
    check("single_level", 32'(level), 1);
    check("single_empty", 32'(fifo_empty), 0);
    check("single_partial", 32'(partial_cnt), 0);
    drain(1);
    check("single_drained", 32'(fifo_empty), 1);

    // Fill to 16, 17th word dropped.
    for (int i = 0; i < 17; i++) send_word(word_of(i), 1'b0, i < 16);
    check("fill_full", 32'(fifo_full), 1);
    check("fill_level", 32'(level), 16);
    check("fill_overrun", 32'(overrun), 1);
    check("fill_head", rd_data, word_of(0));
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    check("clr_overrun", 32'(overrun), 0);

    // Push and pop in the same cycle while full.
    send_word(32'hDEADBEEF, 1'b1, 1'b1);
    check("pushpop_level", 32'(level), 16);
    check("pushpop_overrun", 32'(overrun), 0);
    check("pushpop_head", rd_data, word_of(1));
    drain(16);
    check("pushpop_empty", 32'(fifo_empty), 1);

    // Wrap-around: stream 40 words, rd_en every other cycle.
    lvl = 0; max_dut = 0; ph = 1'b0;
    for (int w = 0; w < 40; w++) begin
      for (int k = 0; k < 4; k++) begin
        p   = (k == 3);
        r   = ph;
        ph  = ~ph;
        acc = p && (lvl < 16 || r);
        pp  = r && (lvl > 0);
        if (acc) exp_q.push_back(word_of(w + 32));
        rx_valid = 1'b1;
        rx_byte  = word_of(w + 32) >> (k * 8);
        rd_en    = r;
        tick();
        lvl = lvl + int'(acc) - int'(pp);
        if (int'(level) > max_dut) max_dut = int'(level);
      end
    end
    rx_valid = 1'b0;
    rd_en    = 1'b0;
    check("wrap_level", 32'(level), 32'(lvl));
    check("wrap_level_bound", 32'(max_dut <= 16), 1);
    drain(lvl);
    check("wrap_empty", 32'(fifo_empty), 1);

    // Flush with a simultaneous byte discards everything.
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    flush = 1'b1; rx_valid = 1'b1; rx_byte = 8'h03;
    tick();
    flush = 1'b0; rx_valid = 1'b0;
    check("flush_partial", 32'(partial_cnt), 0);
    check("flush_level", 32'(level), 0);
    send_word(32'h0D0C0B0A, 1'b0, 1'b1);
    check("after_flush_word", rd_data, 32'h0D0C0B0A);
    drain(1);

    // Drop beats clr_overrun; flush leaves overrun alone.
    for (int i = 0; i < 16; i++) send_word(word_of(i + 64), 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) send_byte(8'hE0 + 8'(k), 1'b0);
    clr_overrun = 1'b1;
    send_byte(8'hE3, 1'b0);
    clr_overrun = 1'b0;
    check("drop_beats_clear", 32'(overrun), 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_keeps_overrun", 32'(overrun), 1);
    check("flush_full_empty", 32'(fifo_empty), 1);
    check("flush_full_level", 32'(level), 0);
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;

    // Asynchronous reset in the middle of a word.
    send_word(32'h55667788, 1'b0, 1'b0);
    send_byte(8'h99, 1'b0);
    send_byte(8'hAA, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check("async_partial", 32'(partial_cnt), 0);
    check("async_level", 32'(level), 0);
    check("async_empty", 32'(fifo_empty), 1);
    check("async_rd_data", rd_data, 0);
    tick();
    reset = 1'b1;
    tick();

`ifdef RX_TIMEOUT_FLUSH_EN
    exp_q.push_back(32'h0000BBAA);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    repeat (7) tick();
    check("timeout_not_yet", 32'(level), 0);
    tick();
    check("timeout_level", 32'(level), 1);
    check("timeout_rd_data", rd_data, 32'h0000BBAA);
    check("timeout_partial", 32'(partial_cnt), 0);
    drain(1);
`endif

    check("queue_drained", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
